// File: rtl/fc2_cu_pkg.sv
// Shared LeNet fully-connected constants and the FC control-unit state encoding.
package lenet_fc_pkg;

    localparam int FC1_IFM_DEPTH    = 120;
    localparam int FC1_NUMBER_OF_WM = 84;
    localparam int FC2_IFM_DEPTH    = 84;
    localparam int FC2_NUMBER_OF_WM = 10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACCUM     = 3'd1,
        S_BIAS      = 3'd2,
        S_DRAIN     = 3'd3,
        S_DONE      = 3'd4,
        S_WAIT_NEXT = 3'd5
    } fc_state_e;

endpackage

// File: rtl/fc2_cu_if.sv
// Handshake and weight/accumulator control bundle between fc2_cu and its datapath neighbours.
interface fc2_cu_if #(
    parameter int ADDRESS_SIZE_WM = 7
);
    logic                       start_from_previous;
    logic                       end_to_previous;
    logic                       end_from_next;
    logic                       start_to_next;
    logic [ADDRESS_SIZE_WM-1:0] wm_address_read;
    logic                       wm_enable_read;
    logic                       acc_enable;
    logic                       acc_clear;
    logic                       bias_sel;
    logic                       ifm_enable_write_next;
    logic                       overrun;

    modport master (
        input  start_from_previous, end_from_next,
        output end_to_previous, start_to_next, wm_address_read, wm_enable_read,
               acc_enable, acc_clear, bias_sel, ifm_enable_write_next, overrun
    );

    modport slave (
        output start_from_previous, end_from_next,
        input  end_to_previous, start_to_next, wm_address_read, wm_enable_read,
               acc_enable, acc_clear, bias_sel, ifm_enable_write_next, overrun
    );
endinterface

// File: rtl/fc2_cu_reg.sv
// Generic pipeline register with asynchronous active-high clear.
module Reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) o_data <= '0;
        else       o_data <= i_data;
    end
endmodule

// File: rtl/fc2_cu.sv
// FC2 control unit: sequences weight reads and accumulation for one inference, then hands off.
// Define FC2_BIAS_EN to add a bias-accumulation cycle after the last product.
module fc2_cu
    import lenet_fc_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IFM_DEPTH       = FC2_IFM_DEPTH,
    parameter int NUMBER_OF_WM    = FC2_NUMBER_OF_WM,
    parameter int ADDRESS_SIZE_WM = $clog2(IFM_DEPTH)
) (
    input  logic     clk,
    input  logic     reset,
    fc2_cu_if.master bus
);
    localparam logic [ADDRESS_SIZE_WM-1:0] LAST_ADDR = ADDRESS_SIZE_WM'(IFM_DEPTH - 1);

    // Datapath width and neuron count only size the datapath; reject nonsense configurations here.
    if (DATA_WIDTH < 1 || NUMBER_OF_WM < 1 || (2 ** ADDRESS_SIZE_WM) < IFM_DEPTH) begin : g_cfg_check
        $error("fc2_cu: invalid parameter set");
    end

    fc_state_e                  r_state;
    fc_state_e                  w_next_state;
    logic [ADDRESS_SIZE_WM-1:0] r_in_count;
    logic                       r_overrun;
    logic                       w_ready;
    logic                       w_accept;
    logic                       w_last_accept;
    logic                       w_acc_dly;
    logic                       w_bias_phase;

`ifdef FC2_BIAS_EN
    localparam fc_state_e POST_LAST = S_BIAS;
    assign w_bias_phase = (r_state == S_DRAIN);
`else
    localparam fc_state_e POST_LAST = S_DRAIN;
    assign w_bias_phase = 1'b0;
`endif

    assign w_ready       = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_accept      = bus.start_from_previous && w_ready;
    assign w_last_accept = w_accept && (r_in_count == LAST_ADDR);

    // The weight memory answers one cycle after the read, so the add follows the accept by one cycle.
    Reg #(.DATA_WIDTH(1)) u_acc_dly (
        .clk    (clk),
        .reset  (reset),
        .i_data (w_accept),
        .o_data (w_acc_dly)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_count <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == S_DONE) r_in_count <= '0;
            else if (w_accept)          r_in_count <= r_in_count + 1'b1;
            if (bus.start_from_previous && !w_ready) r_overrun <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state              = r_state;
        bus.acc_clear             = 1'b0;
        bus.start_to_next         = 1'b0;
        bus.ifm_enable_write_next = 1'b0;
        unique case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_last_accept) w_next_state = POST_LAST;
                else if (w_accept) w_next_state = S_ACCUM;
            end
            S_BIAS:  w_next_state = S_DRAIN;
            S_DRAIN: w_next_state = S_DONE;
            S_DONE: begin
                bus.start_to_next         = 1'b1;
                bus.ifm_enable_write_next = 1'b1;
                w_next_state              = S_WAIT_NEXT;
            end
            S_WAIT_NEXT: begin
                if (bus.end_from_next) begin
                    bus.acc_clear = 1'b1;
                    w_next_state  = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Address is gated by the read enable so the post-last count value never reaches the memory.
    assign bus.end_to_previous = w_ready;
    assign bus.wm_enable_read  = w_accept;
    assign bus.wm_address_read = w_accept ? r_in_count : '0;
    assign bus.acc_enable      = w_acc_dly | w_bias_phase;
    assign bus.bias_sel        = w_bias_phase;
    assign bus.overrun         = r_overrun;

endmodule

// File: doc/fc2_cu.md
FC2_CU -- requirements
Module: fc2_cu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath word width; informational only, not used by control logic.
REQ-002 Parameter IFM_DEPTH, default 84, FC1 values consumed per inference.
REQ-003 Parameter NUMBER_OF_WM, default 10, parallel output neurons sharing one weight address.
REQ-004 Parameter ADDRESS_SIZE_WM, default $clog2(IFM_DEPTH), weight address width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start_from_previous  input  1  one-cycle pulse; FC1 value valid on datapath.
REQ-008 end_to_previous  output  1  ready to accept an FC1 value.
REQ-009 end_from_next  input  1  downstream has consumed the FC2 result.
REQ-010 start_to_next  output  1  one-cycle pulse; FC2 results valid.
REQ-011 wm_address_read  output  ADDRESS_SIZE_WM  weight memory read address.
REQ-012 wm_enable_read  output  1  weight memory read enable.
REQ-013 acc_enable  output  1  all NUMBER_OF_WM accumulators add the current product or bias.
REQ-014 acc_clear  output  1  synchronous clear of all accumulators.
REQ-015 bias_sel  output  1  accumulator adds bias instead of product.
REQ-016 ifm_enable_write_next  output  1  write FC2 results into next-stage buffer.
REQ-017 overrun  output  1  sticky: start_from_previous seen while end_to_previous low.

Function
REQ-018 FSM states: IDLE, ACCUM, BIAS (only with macro), DRAIN, DONE, WAIT_NEXT.
REQ-019 end_to_previous = 1 in IDLE and ACCUM; 0 in all other states.
REQ-020 Accept = start_from_previous AND end_to_previous; on accept, wm_enable_read = 1 and wm_address_read = in_count in the same cycle (combinational).
REQ-021 in_count (ADDRESS_SIZE_WM bits) increments on each accept; reset to 0 on DONE entry and on reset.
REQ-022 acc_enable = accept delayed by exactly one cycle (one-cycle weight memory latency).
REQ-023 IDLE -> ACCUM on first accept; ACCUM holds until accept with in_count == IFM_DEPTH-1.
REQ-024 Last accept at cycle t (no macro): DRAIN at t+1 (acc_enable=1), DONE at t+2.
REQ-025 DONE lasts exactly one cycle: start_to_next = 1, ifm_enable_write_next = 1; then WAIT_NEXT.
REQ-026 WAIT_NEXT holds until end_from_next = 1, then IDLE with acc_clear = 1 for that transition cycle.
REQ-027 end_from_next outside WAIT_NEXT is ignored.
REQ-028 start_from_previous in BIAS/DRAIN/DONE/WAIT_NEXT is not accepted, leaves in_count unchanged, and sets overrun.
REQ-029 start_from_previous and end_from_next in the same WAIT_NEXT cycle: start is not accepted (overrun set); FSM goes to IDLE.
REQ-030 wm_address_read never exceeds IFM_DEPTH-1; no wrap-around within an inference.

Reset
REQ-031 On reset: state IDLE, in_count 0, overrun 0, acc_enable 0, bias_sel 0, start_to_next 0, ifm_enable_write_next 0, acc_clear 0; end_to_previous 1.
REQ-032 Reset mid-inference discards partial count; first accept after release uses address 0.

Configuration
REQ-033 Macro FC2_BIAS_EN: when defined, last accept at t -> BIAS at t+1 (acc_enable=1 for last product), DRAIN at t+2 (acc_enable=1, bias_sel=1), DONE at t+3.
REQ-034 Without FC2_BIAS_EN: no BIAS state; bias_sel is tied to 0.

Structure
REQ-035 Package lenet_fc_pkg holds the FSM state encoding, the FC2 constants (84, 10) and the FC1 constants (120, 84).
REQ-036 The one-cycle accept-to-acc_enable delay uses the existing 1-bit Reg sub-module (DATA_WIDTH=1); there are no other sub-modules.

Verification
REQ-037 Reset, then 84 accept pulses, one every 2 cycles -> addresses 0..83 in order, 84 acc_enable pulses each one cycle after its accept, one start_to_next pulse 2 cycles after the last accept.
REQ-038 84 back-to-back accepts -> start_to_next at cycle 85 after the first accept; end_to_previous low from cycle 84 until end_from_next.
REQ-039 With FC2_BIAS_EN, 84 accepts -> bias_sel=1 with acc_enable exactly once; start_to_next 3 cycles after the last accept.
REQ-040 start_from_previous pulse in WAIT_NEXT -> overrun=1, in_count stays 0, no extra acc_enable; end_from_next -> IDLE with acc_clear=1.
REQ-041 reset asserted after 40 accepts -> all outputs at reset values; the next 84 accepts start at address 0 and complete normally.
REQ-042 end_from_next pulsed during ACCUM -> ignored; FSM still reaches DONE after the 84th accept.
